// File: rtl/apb_ucpd_pkg.sv
// Shared encodings for the UCPD transmit path: descriptor kinds, fail codes, scheduler states.
// Pure declarations, no logic.
package apb_ucpd_pkg;

    typedef enum logic [1:0] {
        KIND_MSG  = 2'd0,
        KIND_HRST = 2'd1,
        KIND_CRST = 2'd2,
        KIND_BIST = 2'd3
    } kind_e;

    typedef enum logic [1:0] {
        FC_NONE     = 2'd0,
        FC_RETRY    = 2'd1,
        FC_UNDERRUN = 2'd2,
        FC_PREEMPT  = 2'd3
    } fail_code_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GAP,
        ST_LOAD,
        ST_SEND,
        ST_HRST
    } state_e;

    typedef struct packed {
        kind_e       kind;
        logic [19:0] ordset;
        logic [9:0]  paysize;
    } desc_t;

endpackage

// File: rtl/apb_ucpd_tx_sched_if.sv
// Descriptor, payload and core-side transmit signals of the TX scheduler.
// master = scheduler, slave = surrounding register/DMA logic and core.
interface apb_ucpd_tx_sched_if;
    logic        ucpden;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_kind;
    logic [19:0] req_ordset;
    logic [9:0]  req_paysize;
    logic        pld_valid;
    logic [7:0]  pld_data;
    logic        pld_ready;
    logic        receive_en;
    logic        txdr_req;
    logic        txsend_clr;
    logic        txhrst_clr;
    logic        tx_msg_disc;
    logic        tx_hrst_disc;
    logic        transmit_en;
    logic        tx_hrst;
    logic [1:0]  tx_mode;
    logic [19:0] tx_ordset;
    logic        tx_ordset_we;
    logic [9:0]  tx_paysize;
    logic [7:0]  ic_txdr;
    logic        txdr_we;
    logic        busy;
    logic        done;
    logic        fail;
    logic [1:0]  fail_code;

    modport master (
        input  ucpden, req_valid, req_kind, req_ordset, req_paysize,
               pld_valid, pld_data, receive_en, txdr_req, txsend_clr,
               txhrst_clr, tx_msg_disc, tx_hrst_disc,
        output req_ready, pld_ready, transmit_en, tx_hrst, tx_mode, tx_ordset,
               tx_ordset_we, tx_paysize, ic_txdr, txdr_we, busy, done, fail, fail_code
    );

    modport slave (
        output ucpden, req_valid, req_kind, req_ordset, req_paysize,
               pld_valid, pld_data, receive_en, txdr_req, txsend_clr,
               txhrst_clr, tx_msg_disc, tx_hrst_disc,
        input  req_ready, pld_ready, transmit_en, tx_hrst, tx_mode, tx_ordset,
               tx_ordset_we, tx_paysize, ic_txdr, txdr_we, busy, done, fail, fail_code
    );
endinterface

// File: rtl/apb_ucpd_gap_timer.sv
// Interframe-gap timer: counts consecutive idle cycles while enabled, restarts on busy or clear.
// term_o is combinational in the GAP_CYC-th idle cycle; the count wraps to 0 after it.
module apb_ucpd_gap_timer #(
    parameter int GAP_CYC = 16
) (
    input  logic ic_clk,
    input  logic ic_rst,
    input  logic en_i,
    input  logic clr_i,
    input  logic busy_i,
    output logic term_o
);
    localparam int CW = $clog2(GAP_CYC + 1);
    localparam logic [CW-1:0] LAST = CW'(GAP_CYC - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign term_o = en_i && !clr_i && !busy_i && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (!en_i || clr_i || busy_i || term_o)
            cnt_d = '0;
        else
            cnt_d = cnt_q + CW'(1);
    end

    always_ff @(posedge ic_clk or posedge ic_rst) begin
        if (ic_rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end
endmodule

// File: rtl/apb_ucpd_tx_sched.sv
// Transmit scheduler for apb_ucpd_core: queues one descriptor, waits an interframe gap, drives the
// core and streams payload on txdr_req; done/fail are registered pulses one cycle after the event.
module apb_ucpd_tx_sched
    import apb_ucpd_pkg::*;
#(
    parameter int GAP_CYC   = 16,
    parameter int MAX_RETRY = 3,
    parameter int RTY_W     = 2
) (
    input  logic                  ic_clk,
    input  logic                  ic_rst,
    apb_ucpd_tx_sched_if.master   bus
);
    state_e     state_q, state_d;
    desc_t      desc_q, desc_d;
    logic [RTY_W-1:0] rty_q, rty_d;
    logic [9:0] sent_q, sent_d;
    logic       done_q, done_d, fail_q, fail_d;
    fail_code_e fc_q, fc_d;

    logic accept, hrst_pend, gap_term, byte_ok, take_byte, can_retry;

    apb_ucpd_gap_timer #(.GAP_CYC(GAP_CYC)) u_gap (
        .ic_clk (ic_clk),
        .ic_rst (ic_rst),
        .en_i   (state_q == ST_GAP),
        .clr_i  (hrst_pend),
        .busy_i (bus.receive_en),
        .term_o (gap_term)
    );

    // Hard reset is the only descriptor accepted outside IDLE; it preempts anything but an HRST.
    assign bus.req_ready = bus.ucpden && ((state_q == ST_IDLE) ||
                           (bus.req_kind == KIND_HRST && state_q != ST_HRST));
    assign accept    = bus.req_valid && bus.req_ready;
    assign hrst_pend = accept && (bus.req_kind == KIND_HRST) && (desc_q.kind != KIND_HRST) &&
                       (state_q inside {ST_GAP, ST_LOAD, ST_SEND});

    assign byte_ok   = (desc_q.kind != KIND_CRST) && (sent_q != desc_q.paysize);
    assign can_retry = (rty_q < RTY_W'(MAX_RETRY));
    assign take_byte = bus.ucpden && (state_q == ST_SEND) && !hrst_pend && !bus.txsend_clr &&
                       !bus.tx_msg_disc && bus.txdr_req && byte_ok && bus.pld_valid;

    always_comb begin
        state_d = state_q;
        desc_d  = desc_q;
        rty_d   = rty_q;
        sent_d  = sent_q;
        done_d  = 1'b0;
        fail_d  = 1'b0;
        fc_d    = FC_NONE;
        if (!bus.ucpden) begin
            state_d = ST_IDLE;
            desc_d  = '0;
            rty_d   = '0;
            sent_d  = '0;
        end else if (hrst_pend) begin
            state_d     = ST_GAP;
            desc_d.kind = KIND_HRST;
            rty_d       = '0;
            sent_d      = '0;
            fail_d      = 1'b1;
            fc_d        = FC_PREEMPT;
        end else begin
            case (state_q)
                ST_IDLE: if (accept) begin
                    state_d        = ST_GAP;
                    desc_d.kind    = kind_e'(bus.req_kind);
                    desc_d.ordset  = bus.req_ordset;
                    desc_d.paysize = bus.req_paysize;
                    rty_d          = '0;
                    sent_d         = '0;
                end
                ST_GAP: if (gap_term)
                    state_d = (desc_q.kind == KIND_HRST) ? ST_HRST : ST_LOAD;
                ST_LOAD: begin
                    state_d = ST_SEND;
                    sent_d  = '0;
                end
                ST_SEND: begin
                    if (bus.txsend_clr) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                        rty_d   = '0;
                    end else if (bus.tx_msg_disc) begin
                        // Replay is only safe if no payload byte has reached the core.
                        if (sent_q == '0 && can_retry) begin
                            state_d = ST_GAP;
                            rty_d   = rty_q + RTY_W'(1);
                        end else begin
                            state_d = ST_IDLE;
                            fail_d  = 1'b1;
                            fc_d    = FC_RETRY;
                        end
                    end else if (bus.txdr_req && byte_ok) begin
                        if (bus.pld_valid) begin
                            sent_d = sent_q + 10'd1;
                        end else begin
                            state_d = ST_IDLE;
                            fail_d  = 1'b1;
                            fc_d    = FC_UNDERRUN;
                        end
                    end
                end
                ST_HRST: begin
                    if (bus.txhrst_clr) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                        rty_d   = '0;
                    end else if (bus.tx_hrst_disc) begin
                        if (can_retry) begin
                            state_d = ST_GAP;
                            rty_d   = rty_q + RTY_W'(1);
                        end else begin
                            state_d = ST_IDLE;
                            fail_d  = 1'b1;
                            fc_d    = FC_RETRY;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge ic_clk or posedge ic_rst) begin
        if (ic_rst) begin
            state_q <= ST_IDLE;
            desc_q  <= '0;
            rty_q   <= '0;
            sent_q  <= '0;
            done_q  <= 1'b0;
            fail_q  <= 1'b0;
            fc_q    <= FC_NONE;
        end else begin
            state_q <= state_d;
            desc_q  <= desc_d;
            rty_q   <= rty_d;
            sent_q  <= sent_d;
            done_q  <= done_d;
            fail_q  <= fail_d;
            fc_q    <= fc_d;
        end
    end

    assign bus.transmit_en  = (state_q == ST_SEND);
    assign bus.tx_hrst      = (state_q == ST_HRST);
    assign bus.tx_mode      = (state_q == ST_HRST) ? KIND_HRST : desc_q.kind;
    assign bus.tx_ordset    = desc_q.ordset;
    assign bus.tx_paysize   = desc_q.paysize;
    assign bus.tx_ordset_we = (state_q == ST_LOAD);
    assign bus.ic_txdr      = take_byte ? bus.pld_data : 8'h00;
    assign bus.txdr_we      = take_byte;
    assign bus.pld_ready    = take_byte;
    assign bus.busy         = (state_q != ST_IDLE);
    assign bus.done         = done_q;
    assign bus.fail         = fail_q;
    assign bus.fail_code    = fc_q;
endmodule

// File: tb/tb_apb_ucpd_tx_sched.sv
// Directed bench for apb_ucpd_tx_sched with GAP_CYC=16, MAX_RETRY=3.
module tb_apb_ucpd_tx_sched;
    logic ic_clk = 1'b0;
    logic ic_rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 ic_clk = ~ic_clk;

    apb_ucpd_tx_sched_if bus ();

    apb_ucpd_tx_sched #(.GAP_CYC(16), .MAX_RETRY(3), .RTY_W(2)) dut (
        .ic_clk (ic_clk),
        .ic_rst (ic_rst),
        .bus    (bus)
    );

    task automatic step();
        @(posedge ic_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_state(input bit hrst, output int n);
        n = 0;
        while (((hrst ? bus.tx_hrst : bus.tx_ordset_we) !== 1'b1) && n < 64) begin
            step();
            n++;
        end
    endtask

    task automatic send_req(input logic [1:0] kind, input logic [19:0] os, input logic [9:0] ps);
        bus.req_valid   = 1'b1;
        bus.req_kind    = kind;
        bus.req_ordset  = os;
        bus.req_paysize = ps;
        #1;
        check("req_ready", bus.req_ready, 1);
        step();
        bus.req_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [7:0] pat [3];
        pat = '{8'hA1, 8'hB2, 8'hC3};
        bus.ucpden = 1'b1;      bus.req_valid = 1'b0;  bus.req_kind = 2'd0;
        bus.req_ordset = '0;    bus.req_paysize = '0;  bus.pld_valid = 1'b0;
        bus.pld_data = '0;      bus.receive_en = 1'b0; bus.txdr_req = 1'b0;
        bus.txsend_clr = 1'b0;  bus.txhrst_clr = 1'b0; bus.tx_msg_disc = 1'b0;
        bus.tx_hrst_disc = 1'b0;
        repeat (3) step();
        check("rst_busy", bus.busy, 0);
        check("rst_ten", bus.transmit_en, 0);
        check("rst_hrst", bus.tx_hrst, 0);
        check("rst_mode", bus.tx_mode, 0);
        check("rst_ordset", bus.tx_ordset, 0);
        check("rst_paysize", bus.tx_paysize, 0);
        check("rst_done", bus.done, 0);
        check("rst_fail", bus.fail, 0);
        check("rst_fc", bus.fail_code, 0);
        check("rst_we", bus.tx_ordset_we, 0);
        ic_rst = 1'b0;
        step();

        // Message, 3 bytes, idle line
        send_req(2'd0, 20'h8E3C6, 10'd3);
        wait_state(1'b0, n);
        check("t1_latency", n + 1, 17);
        check("t1_ordset", bus.tx_ordset, 20'h8E3C6);
        check("t1_paysize", bus.tx_paysize, 3);
        check("t1_mode", bus.tx_mode, 0);
        step();
        check("t1_ten", bus.transmit_en, 1);
        check("t1_we_pulse", bus.tx_ordset_we, 0);
        for (int i = 0; i < 3; i++) begin
            bus.txdr_req = 1'b1; bus.pld_valid = 1'b1; bus.pld_data = pat[i];
            #1;
            check("t1_txdr_we", bus.txdr_we, 1);
            check("t1_ic_txdr", bus.ic_txdr, pat[i]);
            check("t1_pld_ready", bus.pld_ready, 1);
            step();
            bus.txdr_req = 1'b0; bus.pld_valid = 1'b0;
            step();
        end
        bus.txdr_req = 1'b1; bus.pld_valid = 1'b1; bus.pld_data = 8'hDD;
        #1;
        check("t1_extra_we", bus.txdr_we, 0);
        check("t1_extra_rdy", bus.pld_ready, 0);
        step();
        bus.txdr_req = 1'b0; bus.pld_valid = 1'b0;
        bus.txsend_clr = 1'b1;
        #1;
        check("t1_done_early", bus.done, 0);
        step();
        bus.txsend_clr = 1'b0;
        check("t1_done", bus.done, 1);
        check("t1_fail", bus.fail, 0);
        check("t1_busy", bus.busy, 0);
        step();
        check("t1_done_pulse", bus.done, 0);

        // Cable reset with gap restart at count 10
        send_req(2'd2, 20'h12345, 10'd0);
        repeat (10) step();
        check("t2_busy", bus.busy, 1);
        bus.receive_en = 1'b1;
        step();
        bus.receive_en = 1'b0;
        wait_state(1'b0, n);
        check("t2_latency", n, 16);
        check("t2_mode", bus.tx_mode, 2);
        step();
        bus.txdr_req = 1'b1; bus.pld_valid = 1'b1;
        #1;
        check("t2_crst_no_byte", bus.txdr_we, 0);
        step();
        bus.txdr_req = 1'b0; bus.pld_valid = 1'b0;
        bus.txsend_clr = 1'b1;
        step();
        bus.txsend_clr = 1'b0;
        check("t2_done", bus.done, 1);

        // Four discards before any byte: three retries then fail
        send_req(2'd0, 20'h0ABCD, 10'd2);
        wait_state(1'b0, n);
        check("t3_latency", n, 16);
        step();
        for (int i = 0; i < 4; i++) begin
            bus.tx_msg_disc = 1'b1;
            step();
            bus.tx_msg_disc = 1'b0;
            if (i < 3) begin
                check("t3_regap_busy", bus.busy, 1);
                check("t3_regap_ten", bus.transmit_en, 0);
                check("t3_regap_fail", bus.fail, 0);
                wait_state(1'b0, n);
                check("t3_regap_lat", n, 16);
                step();
            end else begin
                check("t3_fail", bus.fail, 1);
                check("t3_fc", bus.fail_code, 1);
                check("t3_ten", bus.transmit_en, 0);
                check("t3_busy", bus.busy, 0);
            end
        end
        step();

        // Payload underrun on second byte
        send_req(2'd0, 20'h55555, 10'd3);
        wait_state(1'b0, n);
        step();
        bus.txdr_req = 1'b1; bus.pld_valid = 1'b1; bus.pld_data = 8'h11;
        step();
        bus.txdr_req = 1'b0; bus.pld_valid = 1'b0;
        step();
        bus.txdr_req = 1'b1;
        #1;
        check("t4_pld_ready", bus.pld_ready, 0);
        check("t4_txdr_we", bus.txdr_we, 0);
        check("t4_ten_hold", bus.transmit_en, 1);
        step();
        bus.txdr_req = 1'b0;
        check("t4_fail", bus.fail, 1);
        check("t4_fc", bus.fail_code, 2);
        check("t4_ten", bus.transmit_en, 0);
        check("t4_done", bus.done, 0);
        step();

        // Hard reset preempts a message mid-SEND
        send_req(2'd0, 20'h8E3C6, 10'd2);
        wait_state(1'b0, n);
        step();
        bus.txdr_req = 1'b1; bus.pld_valid = 1'b1; bus.pld_data = 8'h22;
        step();
        bus.txdr_req = 1'b0; bus.pld_valid = 1'b0;
        send_req(2'd1, 20'h0, 10'd0);
        check("t5_ten", bus.transmit_en, 0);
        check("t5_fail", bus.fail, 1);
        check("t5_fc", bus.fail_code, 3);
        check("t5_busy", bus.busy, 1);
        check("t5_done", bus.done, 0);
        wait_state(1'b1, n);
        check("t5_hrst_lat", n, 16);
        check("t5_mode", bus.tx_mode, 1);
        bus.req_kind = 2'd1;
        #1;
        check("t5_no_ready_hrst", bus.req_ready, 0);
        bus.txhrst_clr = 1'b1;
        step();
        bus.txhrst_clr = 1'b0;
        check("t5_done", bus.done, 1);
        check("t5_hrst_off", bus.tx_hrst, 0);
        check("t5_idle", bus.busy, 0);

        // ucpden dropped during SEND
        send_req(2'd0, 20'h00001, 10'd2);
        wait_state(1'b0, n);
        step();
        check("t6_ten", bus.transmit_en, 1);
        bus.ucpden = 1'b0; bus.txdr_req = 1'b1; bus.pld_valid = 1'b1; bus.pld_data = 8'h33;
        #1;
        check("t6_no_we", bus.txdr_we, 0);
        step();
        bus.txdr_req = 1'b0; bus.pld_valid = 1'b0;
        check("t6_busy", bus.busy, 0);
        check("t6_ten_off", bus.transmit_en, 0);
        check("t6_done", bus.done, 0);
        check("t6_fail", bus.fail, 0);
        check("t6_flush", bus.tx_ordset, 0);
        step();
        check("t6_done2", bus.done, 0);
        check("t6_fail2", bus.fail, 0);
        bus.ucpden = 1'b1;
        step();

        // Asynchronous reset during HRST
        send_req(2'd1, 20'h0, 10'd0);
        wait_state(1'b1, n);
        check("t7_hrst_lat", n, 16);
        check("t7_hrst_on", bus.tx_hrst, 1);
        #2;
        ic_rst = 1'b1;
        #1;
        check("t7_hrst_async", bus.tx_hrst, 0);
        check("t7_busy_async", bus.busy, 0);
        check("t7_mode_async", bus.tx_mode, 0);
        step();
        ic_rst = 1'b0;
        step();
        check("t7_busy_after", bus.busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
